// File: rtl/zipomem_responder.sv
// zipomem_responder: memory-side responder for the zipocpu bus.
// A word-addressed 64-bit RAM is first filled from a valid/ready preload
// stream, starting at INITIAL_PC. The RAM is then handed to the CPU, which
// gets one access per cycle with registered, read-first data.

`ifndef INITIAL_PC
`define INITIAL_PC 64'd0
`endif

module zipomem_responder #(
  parameter int unsigned ADDR_BITS  = 10,
  parameter logic [63:0] INITIAL_PC = `INITIAL_PC,
  parameter logic [63:0] NOP_WORD   = 64'h13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rw,
  input  logic [63:0] addr,
  input  logic [63:0] write,
  output logic [63:0] read,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic        reload,
  output logic        running,
  output logic        addr_err,
  output logic        load_ovf
);

  localparam int unsigned          DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] START_IDX = INITIAL_PC[ADDR_BITS-1:0];
  localparam logic [ADDR_BITS-1:0] LAST_IDX  = '1;

  typedef enum logic {
    ST_LOAD,
    ST_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] load_ptr_q, load_ptr_d;
  logic                 load_ovf_d;
  logic                 addr_err_d;
  logic [63:0]          read_d;

  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_idx;
  logic [63:0]          mem_wdata;
  logic [63:0]          mem [DEPTH];

  logic                 in_range;
  logic [ADDR_BITS-1:0] cpu_idx;

  assign in_range   = (addr[63:ADDR_BITS] == '0);
  assign cpu_idx    = addr[ADDR_BITS-1:0];
  assign load_ready = (state_q == ST_LOAD);
  assign running    = (state_q == ST_RUN);

  // Next-state, RAM write port and next read word for the current cycle.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    load_ovf_d = load_ovf;
    addr_err_d = 1'b0;
    read_d     = NOP_WORD;
    mem_we     = 1'b0;
    mem_idx    = load_ptr_q;
    mem_wdata  = load_data;

    case (state_q)
      ST_LOAD: begin
        // CPU side is ignored while loading; read stays at NOP_WORD.
        if (load_valid) begin
          mem_we     = 1'b1;
          load_ptr_d = load_ptr_q + ADDR_BITS'(1);
          if (load_last) begin
            state_d = ST_RUN;
          end else if (load_ptr_q == LAST_IDX) begin
            load_ovf_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (in_range) begin
          // Read-first: the read word is the RAM content before this
          // cycle's write lands.
          read_d = mem[cpu_idx];
          if (rw) begin
            mem_we    = 1'b1;
            mem_idx   = cpu_idx;
            mem_wdata = write;
          end
        end else begin
          addr_err_d = 1'b1;
        end
        // The CPU access of the reload cycle still completes normally.
        if (reload) begin
          state_d    = ST_LOAD;
          load_ptr_d = START_IDX;
          load_ovf_d = 1'b0;
        end
      end
    endcase
  end

  // Control state and registered CPU-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      load_ptr_q <= START_IDX;
      read       <= NOP_WORD;
      addr_err   <= 1'b0;
      load_ovf   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
      read       <= read_d;
      addr_err   <= addr_err_d;
      load_ovf   <= load_ovf_d;
    end
  end

  // RAM write port; a write is dropped while reset is asserted.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; its contents survive rst_n.
    if (mem_we && rst_n) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_zipomem_responder.sv
// Self-checking bench for zipomem_responder: directed scenarios plus a
// randomized RUN phase checked against an array-based reference model.

module tb_zipomem_responder;

  localparam int          AB    = 10;
  localparam int          DEPTH = 1 << AB;
  localparam int          SAB   = 2;
  localparam logic [63:0] NOP   = 64'h13;
  localparam logic [63:0] IPC   = 64'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        rw = 1'b0, load_valid = 1'b0, load_last = 1'b0, reload = 1'b0;
  logic [63:0] addr = '0, wdata = '0, load_data = '0;
  logic [63:0] read;
  logic        load_ready, running, addr_err, load_ovf;

  logic        s_rw = 1'b0, s_load_valid = 1'b0, s_load_last = 1'b0, s_reload = 1'b0;
  logic [63:0] s_addr = '0, s_wdata = '0, s_load_data = '0;
  logic [63:0] s_read;
  logic        s_load_ready, s_running, s_addr_err, s_load_ovf;

  zipomem_responder #(.ADDR_BITS(AB), .INITIAL_PC(IPC), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .rw(rw), .addr(addr), .write(wdata), .read(read),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .load_last(load_last), .reload(reload), .running(running),
    .addr_err(addr_err), .load_ovf(load_ovf)
  );

  zipomem_responder #(.ADDR_BITS(SAB), .INITIAL_PC(64'd0), .NOP_WORD(NOP)) dut_small (
    .clk(clk), .rst_n(rst_n), .rw(s_rw), .addr(s_addr), .write(s_wdata), .read(s_read),
    .load_valid(s_load_valid), .load_ready(s_load_ready), .load_data(s_load_data),
    .load_last(s_load_last), .reload(s_reload), .running(s_running),
    .addr_err(s_addr_err), .load_ovf(s_load_ovf)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model of the large instance: mode, pointer, sticky flag and
  // a RAM image with a per-word "contents known" flag.
  bit          m_run;
  int          m_ptr;
  bit          m_ovf;
  logic [63:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [63:0] e_read;
  bit          e_read_known;
  bit          e_err;

  logic [63:0] a_words [4];

  task automatic model_edge();
    int idx;
    if (!m_run) begin
      e_read = NOP; e_read_known = 1'b1; e_err = 1'b0;
      if (load_valid) begin
        m_mem[m_ptr] = load_data;
        m_known[m_ptr] = 1'b1;
        if (load_last) m_run = 1'b1;
        else if (m_ptr == DEPTH - 1) m_ovf = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
    end else begin
      if ((addr >> AB) == 64'd0) begin
        idx = int'(addr);
        e_read = m_mem[idx]; e_read_known = m_known[idx]; e_err = 1'b0;
        if (rw) begin m_mem[idx] = wdata; m_known[idx] = 1'b1; end
      end else begin
        e_read = NOP; e_read_known = 1'b1; e_err = 1'b1;
      end
      if (reload) begin m_run = 1'b0; m_ptr = int'(IPC % DEPTH); m_ovf = 1'b0; end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    m_run = 1'b0; m_ptr = int'(IPC % DEPTH); m_ovf = 1'b0;
    e_read = NOP; e_read_known = 1'b1; e_err = 1'b0;
    #2;
  endtask

  task automatic release_reset();
    load_valid = 1'b0; load_last = 1'b0; rw = 1'b0; reload = 1'b0;
    s_load_valid = 1'b0; s_load_last = 1'b0; s_rw = 1'b0; s_reload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic load_word(input logic [63:0] d, input bit last);
    load_valid = 1'b1; load_data = d; load_last = last;
    step();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic cpu(input bit w, input logic [63:0] a, input logic [63:0] d, input bit rl);
    rw = w; addr = a; wdata = d; reload = rl;
    step();
    rw = 1'b0; reload = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    assert_reset();
    n_total++; if (read !== NOP) $display("FAIL reset_read: got %h expected %h", read, NOP); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", load_ready); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL reset_running: got %b expected 0", running); else n_pass++;
    n_total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b expected 0", addr_err); else n_pass++;
    n_total++; if (load_ovf !== 1'b0) $display("FAIL reset_load_ovf: got %b expected 0", load_ovf); else n_pass++;
    release_reset();
  endtask

  task automatic test_load_ignores_cpu();
    cpu(1'b0, 64'd2, 64'd0, 1'b0);
    n_total++; if (read !== NOP) $display("FAIL load_cpu_read: got %h expected %h", read, NOP); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL load_cpu_ready: got %b expected 1", load_ready); else n_pass++;
    n_total++; if (addr_err !== 1'b0) $display("FAIL load_cpu_err: got %b expected 0", addr_err); else n_pass++;
    cpu(1'b0, 64'h1 << 40, 64'd0, 1'b0);
    n_total++; if (addr_err !== 1'b0) $display("FAIL load_oor_err: got %b expected 0", addr_err); else n_pass++;
  endtask

  task automatic test_load_and_read();
    for (int i = 0; i < 4; i++) a_words[i] = {$urandom, $urandom};
    for (int i = 0; i < 4; i++) begin
      load_word(a_words[i], i == 3);
      n_total++;
      if (running !== (i == 3)) $display("FAIL load_running_%0d: got %b expected %b", i, running, i == 3);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      cpu(1'b0, 64'(i), 64'd0, 1'b0);
      n_total++;
      if (read !== a_words[i]) $display("FAIL run_read_%0d: got %h expected %h", i, read, a_words[i]);
      else n_pass++;
    end
  endtask

  task automatic test_read_first();
    logic [63:0] v1;
    v1 = {$urandom, $urandom};
    cpu(1'b1, 64'd5, v1, 1'b0);
    cpu(1'b1, 64'd5, 64'hDEAD_BEEF, 1'b0);
    n_total++; if (read !== v1) $display("FAIL read_first_old: got %h expected %h", read, v1); else n_pass++;
    cpu(1'b0, 64'd5, 64'd0, 1'b0);
    n_total++; if (read !== 64'hDEAD_BEEF) $display("FAIL read_first_new: got %h expected %h", read, 64'hDEAD_BEEF); else n_pass++;
  endtask

  task automatic test_addr_err();
    cpu(1'b1, 64'h1 << AB, 64'hBAD0_BAD0, 1'b0);
    n_total++; if (addr_err !== 1'b1) $display("FAIL oor_err: got %b expected 1", addr_err); else n_pass++;
    n_total++; if (read !== NOP) $display("FAIL oor_read: got %h expected %h", read, NOP); else n_pass++;
    cpu(1'b0, 64'd0, 64'd0, 1'b0);
    n_total++; if (addr_err !== 1'b0) $display("FAIL oor_err_clear: got %b expected 0", addr_err); else n_pass++;
    n_total++; if (read !== a_words[0]) $display("FAIL oor_mem0: got %h expected %h", read, a_words[0]); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] a;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = {$urandom, $urandom};
        if ((a >> AB) == 64'd0) a[40] = 1'b1;
      end else begin
        a = 64'($urandom_range(0, 15));
      end
      cpu(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 1'b0);
      if (e_read_known) begin
        n_total++;
        if (read !== e_read) $display("FAIL rand_read_%0d: got %h expected %h", i, read, e_read);
        else n_pass++;
      end
      n_total++;
      if (addr_err !== e_err) $display("FAIL rand_err_%0d: got %b expected %b", i, addr_err, e_err);
      else n_pass++;
    end
    n_total++; if (running !== m_run) $display("FAIL rand_running: got %b expected %b", running, m_run); else n_pass++;
  endtask

  task automatic test_reload();
    logic [63:0] v9, b0, b1;
    logic [63:0] old9;
    bit          old9_known;
    v9 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    old9 = m_mem[9]; old9_known = m_known[9];
    cpu(1'b1, 64'd9, v9, 1'b1);
    n_total++; if (running !== 1'b0) $display("FAIL reload_running: got %b expected 0", running); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL reload_ready: got %b expected 1", load_ready); else n_pass++;
    if (old9_known) begin
      n_total++; if (read !== old9) $display("FAIL reload_read: got %h expected %h", read, old9); else n_pass++;
    end
    cpu(1'b0, 64'd0, 64'd0, 1'b1);
    n_total++; if (read !== NOP) $display("FAIL reload_nop: got %h expected %h", read, NOP); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL reload_in_load: got %b expected 0", running); else n_pass++;
    load_word(b0, 1'b0);
    load_word(b1, 1'b1);
    n_total++; if (running !== 1'b1) $display("FAIL reload_rerun: got %b expected 1", running); else n_pass++;
    cpu(1'b0, 64'd0, 64'd0, 1'b0);
    n_total++; if (read !== b0) $display("FAIL reload_b0: got %h expected %h", read, b0); else n_pass++;
    cpu(1'b0, 64'd9, 64'd0, 1'b0);
    n_total++; if (read !== v9) $display("FAIL reload_write_kept: got %h expected %h", read, v9); else n_pass++;
    cpu(1'b0, 64'd1, 64'd0, 1'b0);
    n_total++; if (read !== b1) $display("FAIL reload_b1: got %h expected %h", read, b1); else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    logic [63:0] d [3];
    assert_reset();
    release_reset();
    load_word({$urandom, $urandom}, 1'b0);
    load_word({$urandom, $urandom}, 1'b0);
    assert_reset();
    n_total++; if (read !== NOP) $display("FAIL midrst_read: got %h expected %h", read, NOP); else n_pass++;
    n_total++; if (running !== 1'b0) $display("FAIL midrst_running: got %b expected 0", running); else n_pass++;
    n_total++; if (load_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", load_ready); else n_pass++;
    release_reset();
    for (int i = 0; i < 3; i++) d[i] = {$urandom, $urandom};
    for (int i = 0; i < 3; i++) load_word(d[i], i == 2);
    n_total++; if (running !== 1'b1) $display("FAIL midrst_run: got %b expected 1", running); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cpu(1'b0, 64'(i), 64'd0, 1'b0);
      n_total++;
      if (read !== d[i]) $display("FAIL midrst_read_%0d: got %h expected %h", i, read, d[i]);
      else n_pass++;
    end
    cpu(1'b0, 64'd0, 64'd0, 1'b1);
    n_total++; if (running !== 1'b0) $display("FAIL midrst_reload: got %b expected 0", running); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [63:0] w [6];
    assert_reset();
    release_reset();
    for (int i = 0; i < 6; i++) w[i] = {$urandom, $urandom};
    for (int i = 0; i < 6; i++) begin
      s_load_valid = 1'b1; s_load_data = w[i]; s_load_last = (i == 5);
      step();
      s_load_valid = 1'b0; s_load_last = 1'b0;
      // Pointer runs 0,1,2,3 then wraps; the fourth word is the first
      // written at the top index without load_last.
      n_total++;
      if (s_load_ovf !== (i >= 3)) $display("FAIL ovf_flag_%0d: got %b expected %b", i, s_load_ovf, i >= 3);
      else n_pass++;
      if (i == 4) begin
        n_total++; if (s_running !== 1'b0) $display("FAIL ovf_running: got %b expected 0", s_running); else n_pass++;
        n_total++; if (s_load_ready !== 1'b1) $display("FAIL ovf_ready: got %b expected 1", s_load_ready); else n_pass++;
      end
    end
    n_total++; if (s_running !== 1'b1) $display("FAIL ovf_run: got %b expected 1", s_running); else n_pass++;
    // Words 4 and 5 landed at indices 0 and 1 after the wrap.
    for (int i = 0; i < 4; i++) begin
      logic [63:0] exp;
      exp = (i == 0) ? w[4] : (i == 1) ? w[5] : w[i];
      s_addr = 64'(i); s_rw = 1'b0;
      step();
      n_total++;
      if (s_read !== exp) $display("FAIL ovf_read_%0d: got %h expected %h", i, s_read, exp);
      else n_pass++;
    end
    s_addr = 64'd4;
    step();
    n_total++; if (s_addr_err !== 1'b1) $display("FAIL small_oor_err: got %b expected 1", s_addr_err); else n_pass++;
    n_total++; if (s_read !== NOP) $display("FAIL small_oor_read: got %h expected %h", s_read, NOP); else n_pass++;
    s_addr = 64'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    test_reset();
    test_load_ignores_cpu();
    test_load_and_read();
    test_read_first();
    test_addr_err();
    test_random();
    test_reload();
    test_reset_mid_stream();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
